sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Time-multiplexed scan controller that drives a bank of common-anode seven-segment digits through a single shared instance of the existing `sevenseg` decoder. It holds a double-buffered BCD value and enables one digit at a time. A dead-time interval separates digits to prevent ghosting. New values are swapped in only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the numeric datapath and the board's segment and anode pins.

## Interface
- `NDIGITS`, default 4: number of digits scanned (1..8).
- `REFRESH_DIV`, default 50000: cycles each digit is lit (≥1).
- `BLANK_CYCLES`, default 500: dead-time cycles before each digit, with all anodes off (≥1).
- `BLANK_LZ`, default 1: blank leading zeros when 1.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  single-cycle strobe; captures `digits_in` into the pending buffer.
- `digits_in`  in  4*NDIGITS  BCD digits; digit 0 (least significant) is [3:0].
- `segments`  out  7  active-low segments; bit 6 = g … bit 0 = a.
- `anodes`  out  NDIGITS  active-low digit enables; at most one bit is low.
- `pending`  out  1  high while a loaded value awaits its frame swap.
- `frame_start`  out  1  one-cycle pulse on the first DISPLAY cycle of digit 0.

## Operation
- FSM with states S_BLANK and S_DISPLAY, a dwell counter, and digit index `idx` (0..NDIGITS-1).
- S_BLANK: hold for BLANK_CYCLES cycles with `anodes` all 1 and `segments` = 7'h7F. Then go to S_DISPLAY.
- S_DISPLAY: hold for REFRESH_DIV cycles with `anodes[idx]` = 0 and `segments` = decode(active[idx]). Then go to S_BLANK with `idx` = idx+1, wrapping NDIGITS-1 → 0.
- Decoding follows the `sevenseg` map:
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19
  - 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10
  - 10..15 → 7'h7F (blank)
- Leading-zero blanking (BLANK_LZ=1): a digit above the highest nonzero digit shows 7'h7F, but its anode is still driven low. Digit 0 is never blanked, so an all-zero value shows a single "0".
- Buffering:
  - `load` writes `digits_in` into the pending register and sets `pending`.
  - A `load` while `pending` is already set overwrites the pending value; the last load wins.
- Swap: on the S_BLANK→S_DISPLAY transition with idx==0, if `pending` is set, then active ← pending and `pending` clears. Digit 0 of that frame already shows the new value.
- Simultaneous `load` on the swap cycle:
  - The swap uses the previous pending contents, if any.
  - The new data lands in pending with `pending` = 1 and is displayed next frame.
- Reset (asynchronous, at any point, including mid-digit):
  - State S_BLANK, counter 0, idx 0.
  - Active register all 4'hF (blank); pending register all 4'hF; `pending` = 0.
  - `anodes` all 1, `segments` 7'h7F, `frame_start` 0.

## Timing
- All outputs are registered and change only on `clk` edges, except during asynchronous reset.
- After reset deasserts, the first S_DISPLAY cycle (digit 0, `frame_start` = 1) occurs on edge BLANK_CYCLES.
- Digit period = BLANK_CYCLES + REFRESH_DIV. Frame period = NDIGITS × digit period.
- `pending` rises on the edge after `load` and falls on the swap edge.
- Worst-case latency from `load` to display is one frame period plus BLANK_CYCLES.
- `anodes` never has two low bits in any cycle. Every anode change passes through at least BLANK_CYCLES of all-high.

## Structure
- Package `sevenseg_pkg`:
  - `scan_state_t` enum {S_BLANK, S_DISPLAY}
  - `SEG_BLANK` = 7'h7F
  - `BCD_BLANK` = 4'hF
  - counter width function: $clog2 of max(REFRESH_DIV, BLANK_CYCLES)+1
- One sub-module: the existing `sevenseg` decoder, instantiated once and fed by the idx mux (or by `BCD_BLANK` when leading-zero blanking applies). Its output is registered in this block.

## Test plan
All scenarios use NDIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2 (digit period 6, frame period 24).
- Reset, then idle 48 cycles → `anodes` cycle E→F→D→F→B→F→7→F. `segments` 7'h7F throughout, since active is blank. `frame_start` pulses on cycles 2 and 26.
- `load` 16'h1234 at cycle 5 → `pending` = 1 from cycle 6 until cycle 26. The frame starting at cycle 26 shows digit 0 = 7'h19 (4), then 7'h30, 7'h24, 7'h79.
- BLANK_LZ=1 with loaded value 16'h0070 → digit 0 = 7'h40, digit 1 = 7'h78, digits 2–3 = 7'h7F with their anodes still low. Loaded value 16'h0000 → only digit 0 shows 7'h40.
- Load 16'h1111 then 16'h2222 within the same frame → the next frame shows only 2s. A third load on the swap cycle itself is deferred one frame, with `pending` staying 1.
- Assert `reset` mid-S_DISPLAY of digit 2 → asynchronously, `anodes` = 4'hF, `segments` = 7'h7F, `pending` = 0. After release, the scan restarts at digit 0, BLANK_CYCLES later.
- Continuous assertion over 200 cycles: at most one `anodes` bit is low, and any two consecutive distinct low-anode patterns are separated by ≥2 all-high cycles.

Source files
------------

// File: rtl/sevenseg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// The package is named sevenseg_pkg because the decoder and the scanner both use it.
package sevenseg_pkg;

  typedef enum logic {
    S_BLANK   = 1'b0,
    S_DISPLAY = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // The dwell counter must hold the larger of the two dwell lengths.
  function automatic int cnt_width(input int refresh_div, input int blank_cycles);
    int m;
    m = (refresh_div > blank_cycles) ? refresh_div : blank_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// Datapath-side and pin-side signals of the scan controller.
// The master side loads values; the slave side is the scanner itself.
interface sevenseg_scan_if #(
  parameter int NDIGITS = 4
) ();

  logic                   load;
  logic [4*NDIGITS-1:0]   digits_in;
  logic [6:0]             segments;
  logic [NDIGITS-1:0]     anodes;
  logic                   pending;
  logic                   frame_start;

  modport master (
    output load, digits_in,
    input  segments, anodes, pending, frame_start
  );

  modport slave (
    input  load, digits_in,
    output segments, anodes, pending, frame_start
  );

endinterface

// File: rtl/sevenseg.sv
// BCD to common-anode seven-segment decoder (active-low, bit 6 = g .. bit 0 = a).
// Codes 10..15 produce a dark digit.
module sevenseg
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan of NDIGITS common-anode digits with dead time between digits.
// Loaded values wait in a pending buffer and are swapped in only at the start of a frame.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS      = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLANK_LZ     = 1
) (
  input  logic           clk,
  input  logic           reset,
  sevenseg_scan_if.slave bus
);

  localparam int CW = cnt_width(REFRESH_DIV, BLANK_CYCLES);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef logic [NDIGITS-1:0][3:0] bcd_vec_t;

  scan_state_t         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  bcd_vec_t            active_q, active_d;
  bcd_vec_t            pend_q, pend_d;
  logic                pending_q, pending_d;
  logic [NDIGITS-1:0]  anodes_q, anodes_d;
  logic [6:0]          segments_q, segments_d;
  logic                frame_start_q, frame_start_d;
  logic                swap;
  logic [NDIGITS-1:0]  lz_blank;
  logic                lz_seen;
  logic [3:0]          dec_in;
  logic [6:0]          dec_out;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    active_d      = active_q;
    pend_d        = pend_q;
    pending_d     = pending_q;
    swap          = 1'b0;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = S_DISPLAY;
          cnt_d   = '0;
          swap    = (idx_q == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DISPLAY: begin
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_BLANK;
    endcase

    if (swap && pending_q) begin
      active_d  = pend_q;
      pending_d = 1'b0;
    end
    // A load on the swap edge lands behind the swap and waits for the next frame.
    if (bus.load) begin
      pend_d    = bcd_vec_t'(bus.digits_in);
      pending_d = 1'b1;
    end

    frame_start_d = swap;
    anodes_d      = '1;
    if (state_d == S_DISPLAY) anodes_d[idx_d] = 1'b0;
  end

  // Digits above the highest nonzero digit are dark; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    lz_seen  = 1'b0;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      if (active_d[i] != 4'h0) lz_seen = 1'b1;
      lz_blank[i] = !lz_seen;
    end
  end

  always_comb begin
    dec_in = BCD_BLANK;
    if ((state_d == S_DISPLAY) && !((BLANK_LZ != 0) && lz_blank[idx_d]))
      dec_in = active_d[idx_d];
  end

  sevenseg u_dec (
    .bcd (dec_in),
    .seg (dec_out)
  );

  assign segments_d = dec_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      active_q      <= bcd_vec_t'({NDIGITS{BCD_BLANK}});
      pend_q        <= bcd_vec_t'({NDIGITS{BCD_BLANK}});
      pending_q     <= 1'b0;
      anodes_q      <= '1;
      segments_q    <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pending_q     <= pending_d;
      anodes_q      <= anodes_d;
      segments_q    <= segments_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.segments    = segments_q;
  assign bus.anodes      = anodes_q;
  assign bus.pending     = pending_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan with NDIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.
// Stimulus queues expected digit starts and pending levels; a negedge monitor checks them.
module tb_sevenseg_scan;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sevenseg_scan_if #(.NDIGITS(4)) bus();

  sevenseg_scan #(
    .NDIGITS      (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (2),
    .BLANK_LZ     (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } dig_t;

  typedef struct {
    int   cyc;
    logic val;
  } pend_t;

  dig_t  sb[$];
  pend_t pq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  // Snapshot taken by stimulus right after an asynchronous reset assertion.
  int         snap_id = 0;
  logic [3:0] snap_an;
  logic [6:0] snap_seg;
  logic       snap_pend;
  logic       snap_fs;

  // Monitor-only state.
  int         seen_snap = 0;
  logic [3:0] prev_an = 4'hF;
  logic [3:0] last_low = 4'hF;
  bit         last_valid = 0;
  bit         in_rst = 0;
  int         blank_run = 0;
  dig_t       e;
  pend_t      p;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (snap_id != seen_snap) begin
      seen_snap = snap_id;
      chk("async_rst_anodes",   int'(snap_an),   'hF);
      chk("async_rst_segments", int'(snap_seg),  'h7F);
      chk("async_rst_pending",  int'(snap_pend), 0);
      chk("async_rst_fs",       int'(snap_fs),   0);
    end
    if (reset) begin
      if (!in_rst) begin
        chk("drain_digits",  sb.size(), 0);
        chk("drain_pending", pq.size(), 0);
        sb.delete();
        pq.delete();
        in_rst = 1;
      end
      chk("rst_anodes", int'(bus.anodes), 'hF);
      prev_an    = 4'hF;
      last_valid = 0;
      blank_run  = 0;
    end else begin
      in_rst = 0;
      chk($sformatf("one_low_c%0d", cyc), ($countones(~bus.anodes) <= 1) ? 1 : 0, 1);
      if (bus.anodes == 4'hF) begin
        blank_run++;
      end else begin
        if (last_valid && bus.anodes != last_low)
          chk($sformatf("deadtime_c%0d", cyc), (blank_run >= 2) ? 1 : 0, 1);
        last_low   = bus.anodes;
        last_valid = 1;
        blank_run  = 0;
      end
      if (prev_an == 4'hF && bus.anodes != 4'hF) begin
        if (sb.size() == 0) begin
          chk($sformatf("unexpected_digit_c%0d", cyc), int'(bus.anodes), 'hF);
        end else begin
          e = sb.pop_front();
          chk($sformatf("digit_cycle_an%0h", e.an), cyc, e.cyc);
          chk($sformatf("anodes_c%0d", e.cyc), int'(bus.anodes), int'(e.an));
          chk($sformatf("segments_c%0d", e.cyc), int'(bus.segments), int'(e.seg));
          chk($sformatf("frame_start_c%0d", e.cyc), int'(bus.frame_start), int'(e.fs));
        end
      end else if (bus.frame_start) begin
        chk($sformatf("stray_frame_start_c%0d", cyc), int'(bus.frame_start), 0);
      end
      prev_an = bus.anodes;
      while (pq.size() != 0 && pq[0].cyc <= cyc) begin
        p = pq.pop_front();
        chk($sformatf("pending_c%0d", p.cyc), (p.cyc == cyc) ? int'(bus.pending) : -1,
            int'(p.val));
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 1000) begin
      @(posedge clk);
      #2;
      guard++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.load = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic load_at(input int c, input logic [15:0] v);
    wait_cyc(c);
    bus.load      = 1'b1;
    bus.digits_in = v;
    @(posedge clk);
    #2;
    bus.load = 1'b0;
  endtask

  task automatic push_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = 0; k < 4; k++) begin
      dig_t d;
      d.cyc = base + 6 * k;
      d.an  = ~(4'b0001 << k);
      d.seg = s[k];
      d.fs  = (k == 0);
      sb.push_back(d);
    end
  endtask

  task automatic push_pend(input int c, input logic v);
    pend_t q;
    q.cyc = c;
    q.val = v;
    pq.push_back(q);
  endtask

  localparam logic [6:0] B = 7'h7F;

  initial begin
    reset         = 1'b1;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    @(posedge clk);
    #2;
    do_reset();

    // Idle: blank display, digit starts at 2,8,14,20 and 26,32,38,44.
    push_frame(2, B, B, B, B);
    push_frame(26, B, B, B, B);
    wait_cyc(48);

    // Single load of 1234 swapped at cycle 26.
    do_reset();
    push_frame(2, B, B, B, B);
    push_frame(26, 7'h19, 7'h30, 7'h24, 7'h79);
    push_pend(5, 0); push_pend(6, 1); push_pend(25, 1); push_pend(26, 0);
    load_at(5, 16'h1234);
    wait_cyc(48);

    // Leading-zero blanking: 0070, then 0000.
    do_reset();
    push_frame(2, B, B, B, B);
    push_frame(26, 7'h40, 7'h78, B, B);
    push_frame(50, 7'h40, B, B, B);
    push_pend(26, 0); push_pend(31, 1); push_pend(50, 0);
    load_at(5, 16'h0070);
    load_at(30, 16'h0000);
    wait_cyc(72);

    // Last load wins; a load on the swap edge is deferred one frame.
    do_reset();
    push_frame(2, B, B, B, B);
    push_frame(26, 7'h24, 7'h24, 7'h24, 7'h24);
    push_frame(50, 7'h12, 7'h12, 7'h12, 7'h12);
    push_frame(74, 7'h30, 7'h30, 7'h30, 7'h30);
    push_pend(6, 1); push_pend(11, 1); push_pend(26, 0); push_pend(41, 1);
    push_pend(49, 1); push_pend(50, 1); push_pend(73, 1); push_pend(74, 0);
    load_at(5, 16'h1111);
    load_at(10, 16'h2222);
    load_at(40, 16'h5555);
    load_at(49, 16'h3333);
    wait_cyc(96);

    // Asynchronous reset in the middle of digit 2, with a value pending.
    do_reset();
    begin
      dig_t d;
      d.cyc = 2;  d.an = 4'hE; d.seg = B; d.fs = 1; sb.push_back(d);
      d.cyc = 8;  d.an = 4'hD; d.seg = B; d.fs = 0; sb.push_back(d);
      d.cyc = 14; d.an = 4'hB; d.seg = B; d.fs = 0; sb.push_back(d);
    end
    push_pend(10, 1);
    load_at(5, 16'h1234);
    wait_cyc(15);
    #1;
    reset = 1'b1;
    #1;
    snap_an   = bus.anodes;
    snap_seg  = bus.segments;
    snap_pend = bus.pending;
    snap_fs   = bus.frame_start;
    snap_id++;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    begin
      dig_t d;
      d.cyc = 2; d.an = 4'hE; d.seg = B; d.fs = 1; sb.push_back(d);
      d.cyc = 8; d.an = 4'hD; d.seg = B; d.fs = 0; sb.push_back(d);
    end
    push_pend(3, 0);
    wait_cyc(12);

    do_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
